// File: rtl/card_pkg.sv
// Shared card types, shoe FSM states and the LFSR step
// used by the card shoe and other game randomness.
package card_pkg;

    localparam int CARDS_PER_DECK = 52;
    localparam int RANKS          = 13;
    localparam int SUITS          = 4;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef logic [3:0] rank_t;
    typedef logic [1:0] suit_t;

    typedef struct packed {
        suit_t suit;
        rank_t rank;
    } card_t;

    typedef enum logic [1:0] {
        S_INIT,
        S_SHUFFLE,
        S_READY,
        S_EMPTY
    } shoe_state_t;

    // One Galois right-shift step.
    function automatic logic [15:0] lfsrNext(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/card_shoe_if.sv
// Draw/shuffle handshake and status between the shoe
// and the game controller.
interface card_shoe_if;
    import card_pkg::*;

    logic        i_draw_req;
    logic        i_shuffle_req;
    card_t       o_card;
    logic        o_card_valid;
    logic        o_ready;
    logic        o_busy;
    logic        o_empty;
    logic [7:0]  o_cards_left;

    modport master (
        output i_draw_req,
        output i_shuffle_req,
        input  o_card,
        input  o_card_valid,
        input  o_ready,
        input  o_busy,
        input  o_empty,
        input  o_cards_left
    );

    modport slave (
        input  i_draw_req,
        input  i_shuffle_req,
        output o_card,
        output o_card_valid,
        output o_ready,
        output o_busy,
        output o_empty,
        output o_cards_left
    );

endinterface

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR; recovers to SEED
// if it is ever found in the all-zero lock-up state.
module lfsr16
    import card_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    output logic [15:0] o_state
);

    // Step every cycle; escape the zero state.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_state <= SEED;
        end else if (o_state == 16'h0000) begin
            o_state <= SEED;
        end else begin
            o_state <= lfsrNext(o_state);
        end
    end

endmodule

// File: rtl/card_shoe.sv
// Multi-deck card shoe with hardware Fisher-Yates shuffle.
// Option: CARD_SHOE_AUTO_RESHUFFLE_EN refills at RESHUFFLE_AT.
module card_shoe
    import card_pkg::*;
#(
    parameter int          NUM_DECKS    = 1,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1,
    parameter int          RESHUFFLE_AT = 15
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    card_shoe_if.slave bus
);

    localparam int DECK_SIZE = CARDS_PER_DECK * NUM_DECKS;
    localparam int IDX_W     = $clog2(DECK_SIZE);

    localparam logic [7:0] LAST   = 8'(DECK_SIZE - 1);
    localparam logic [7:0] FULL   = 8'(DECK_SIZE);
    localparam logic [7:0] THRESH = 8'(RESHUFFLE_AT);

    shoe_state_t state;
    card_t       deck [DECK_SIZE];

    logic [7:0]  idx;
    logic [7:0]  ptr;
    logic [7:0]  cardsLeft;
    rank_t       initRank;
    suit_t       initSuit;
    card_t       cardQ;
    logic        cardValid;

    logic [15:0] lfsr;
    logic [7:0]  cand;
    logic        swapEn;
    logic        unusedBits;

    logic [IDX_W-1:0] idxA;
    logic [IDX_W-1:0] candA;
    logic [IDX_W-1:0] ptrA;

    lfsr16 #(.SEED(LFSR_SEED)) uLfsr (
        .i_clk    (i_clk),
        .i_reset_n(i_reset_n),
        .o_state  (lfsr)
    );

    assign cand   = 8'(lfsr[IDX_W-1:0]);
    assign idxA   = idx[IDX_W-1:0];
    assign candA  = cand[IDX_W-1:0];
    assign ptrA   = ptr[IDX_W-1:0];
    assign swapEn = (state == S_SHUFFLE) && (idx != 8'd0)
                  && (cand <= idx);

    assign unusedBits = &{1'b0, lfsr[15:IDX_W], THRESH};

    // Card storage: sequential fill, then in-place swaps.
    always_ff @(posedge i_clk) begin
        if (state == S_INIT) begin
            deck[idxA] <= {initSuit, initRank};
        end else if (swapEn) begin
            deck[idxA]  <= deck[candA];
            deck[candA] <= deck[idxA];
        end
    end

    // Shoe sequencer: fill, shuffle, deal, drain.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state     <= S_INIT;
            idx       <= '0;
            ptr       <= '0;
            cardsLeft <= '0;
            initRank  <= 4'd1;
            initSuit  <= '0;
            cardQ     <= '0;
            cardValid <= 1'b0;
        end else begin
            cardValid <= 1'b0;
            unique case (state)
                S_INIT: begin
                    if (initRank == rank_t'(RANKS)) begin
                        initRank <= 4'd1;
                        initSuit <= initSuit + 2'd1;
                    end else begin
                        initRank <= initRank + 4'd1;
                    end
                    if (idx == LAST) begin
                        initRank <= 4'd1;
                        initSuit <= '0;
                        state    <= S_SHUFFLE;
                    end else begin
                        idx <= idx + 8'd1;
                    end
                end
                S_SHUFFLE: begin
                    if (idx == 8'd0) begin
                        ptr       <= '0;
                        cardsLeft <= FULL;
                        state     <= S_READY;
                    end else if (swapEn) begin
                        idx <= idx - 8'd1;
                    end
                end
                S_READY: begin
                    if (bus.i_shuffle_req) begin
                        state     <= S_INIT;
                        idx       <= '0;
                        cardsLeft <= '0;
                    end else if (bus.i_draw_req) begin
                        cardQ     <= deck[ptrA];
                        cardValid <= 1'b1;
                        ptr       <= ptr + 8'd1;
                        cardsLeft <= cardsLeft - 8'd1;
`ifdef CARD_SHOE_AUTO_RESHUFFLE_EN
                        if (cardsLeft - 8'd1 <= THRESH) begin
                            state     <= S_INIT;
                            idx       <= '0;
                            cardsLeft <= '0;
                        end
`else
                        if (cardsLeft == 8'd1) begin
                            state <= S_EMPTY;
                        end
`endif
                    end
                end
                S_EMPTY: begin
                    if (bus.i_shuffle_req) begin
                        state     <= S_INIT;
                        idx       <= '0;
                        cardsLeft <= '0;
                    end
                end
                default: state <= S_INIT;
            endcase
        end
    end

    assign bus.o_card       = cardQ;
    assign bus.o_card_valid = cardValid;
    assign bus.o_cards_left = cardsLeft;
    assign bus.o_busy       = (state == S_INIT)
                            || (state == S_SHUFFLE);
    assign bus.o_ready      = (state == S_READY);
    assign bus.o_empty      = (state == S_EMPTY);

endmodule

// File: tb/tb_card_shoe.sv
// Directed-random bench for card_shoe: one-deck and
// two-deck shoes checked against a counting model.
module tb_card_shoe;
    import card_pkg::*;

    localparam int D1  = 52;
    localparam int D2  = 104;
    localparam int THR = 15;
`ifdef CARD_SHOE_AUTO_RESHUFFLE_EN
    localparam int DRAIN1 = D1 - THR;
    localparam int DRAIN2 = D2 - THR;
`else
    localparam int DRAIN1 = D1;
    localparam int DRAIN2 = D2;
`endif
    localparam bit FULL1 = (DRAIN1 == D1);
    localparam bit FULL2 = (DRAIN2 == D2);

    logic clk = 1'b0;
    logic rst1;
    logic rst2;
    int   asserts = 0;
    int   fails   = 0;

    card_t drawn [$];
    card_t run1  [$];
    card_t q2    [$];

    card_shoe_if bus1 ();
    card_shoe_if bus2 ();

    card_shoe #(
        .NUM_DECKS   (1),
        .LFSR_SEED   (16'hACE1),
        .RESHUFFLE_AT(THR)
    ) dut1 (
        .i_clk    (clk),
        .i_reset_n(rst1),
        .bus      (bus1)
    );

    card_shoe #(
        .NUM_DECKS   (2),
        .LFSR_SEED   (16'hACE1),
        .RESHUFFLE_AT(THR)
    ) dut2 (
        .i_clk    (clk),
        .i_reset_n(rst2),
        .bus      (bus2)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        asserts++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d",
                   tag, obs, exp);
        end
    endtask

    // Undealt count the shoe should report after a deal.
    function automatic int expLeft(input int left);
`ifdef CARD_SHOE_AUTO_RESHUFFLE_EN
        if (left <= THR) return 0;
`endif
        return left;
    endfunction

    task automatic resetCheck1(input string tag);
        chk({tag, "_card"},  32'(bus1.o_card), 0);
        chk({tag, "_valid"}, 32'(bus1.o_card_valid), 0);
        chk({tag, "_left"},  32'(bus1.o_cards_left), 0);
        chk({tag, "_ready"}, 32'(bus1.o_ready), 0);
        chk({tag, "_busy"},  32'(bus1.o_busy), 1);
        chk({tag, "_empty"}, 32'(bus1.o_empty), 0);
    endtask

    // Wait for the one-deck shoe to refill, optionally
    // hammering it with draws/shuffles that must be ignored.
    task automatic waitReady1(input int bound,
                              input bit noise,
                              input string tag);
        int n = 0;
        int badValid = 0;
        int sawEmpty = 0;
        while (bus1.o_ready !== 1'b1 && n < bound) begin
            if (bus1.o_empty === 1'b1) sawEmpty++;
            bus1.i_draw_req    = noise ? 1'($urandom_range(1)) : 1'b0;
            bus1.i_shuffle_req = noise ? ($urandom_range(15) == 0) : 1'b0;
            @(negedge clk);
            n++;
            if (bus1.o_card_valid !== 1'b0) badValid++;
        end
        bus1.i_draw_req    = 1'b0;
        bus1.i_shuffle_req = 1'b0;
        chk({tag, "_ready"},   32'(bus1.o_ready), 1);
        chk({tag, "_left"},    32'(bus1.o_cards_left), D1);
        chk({tag, "_nopulse"}, badValid, 0);
        chk({tag, "_noempty"}, sawEmpty, 0);
    endtask

    // Deal n cards with random gaps from a shoe holding startLeft.
    task automatic drawN1(input int n, input int startLeft,
                          input string tag);
        int acc = 0;
        int guard = 0;
        bit pend;
        drawn.delete();
        while (acc < n && guard < 20 * n + 20) begin
            if ($urandom_range(2) != 0) begin
                bus1.i_draw_req = 1'b1;
                acc++;
                pend = 1'b1;
            end else begin
                bus1.i_draw_req = 1'b0;
                pend = 1'b0;
            end
            @(negedge clk);
            guard++;
            chk({tag, "_valid"}, 32'(bus1.o_card_valid), 32'(pend));
            if (pend) begin
                drawn.push_back(bus1.o_card);
            end else if (drawn.size() > 0) begin
                chk({tag, "_hold"}, 32'(bus1.o_card),
                    32'(drawn[drawn.size() - 1]));
            end
            chk({tag, "_left"}, 32'(bus1.o_cards_left),
                expLeft(startLeft - acc));
        end
        bus1.i_draw_req = 1'b0;
        chk({tag, "_count"}, drawn.size(), n);
    endtask

    // Every legal card appears at most (exactly, if full) copies times.
    task automatic permCheck(input card_t cs[$], input int copies,
                             input bit full, input int expN,
                             input string tag);
        int cnt [SUITS][16];
        int bad = 0;
        for (int s = 0; s < SUITS; s++)
            for (int r = 0; r < 16; r++) cnt[s][r] = 0;
        foreach (cs[k]) cnt[cs[k].suit][cs[k].rank]++;
        for (int s = 0; s < SUITS; s++) begin
            for (int r = 0; r < 16; r++) begin
                if (r < 1 || r > RANKS) begin
                    if (cnt[s][r] != 0) bad++;
                end else if (cnt[s][r] > copies) begin
                    bad++;
                end else if (full && cnt[s][r] != copies) begin
                    bad++;
                end
            end
        end
        chk({tag, "_perm"}, bad, 0);
        chk({tag, "_n"}, cs.size(), expN);
    endtask

    initial begin
        int n;
        int mism;
        bus1.i_draw_req    = 1'b0;
        bus1.i_shuffle_req = 1'b0;
        bus2.i_draw_req    = 1'b0;
        bus2.i_shuffle_req = 1'b0;
        rst1 = 1'b1;
        rst2 = 1'b1;

        // Power-on reset, checked asynchronously.
        #2;
        rst1 = 1'b0;
        rst2 = 1'b0;
        #1;
        resetCheck1("por");
        chk("por2_busy", 32'(bus2.o_busy), 1);
        chk("por2_left", 32'(bus2.o_cards_left), 0);
        @(negedge clk);
        @(negedge clk);
        rst1 = 1'b1;
        rst2 = 1'b1;
        chk("init_busy", 32'(bus1.o_busy), 1);

        // First fill+shuffle, then drain and check the permutation.
        waitReady1(1000, 1'b0, "shuf1");
        chk("shuf1_empty", 32'(bus1.o_empty), 0);
        chk("shuf1_busy",  32'(bus1.o_busy), 0);
        drawN1(DRAIN1, D1, "drain1");
        run1 = drawn;
        permCheck(run1, 1, FULL1, DRAIN1, "deck1");

`ifdef CARD_SHOE_AUTO_RESHUFFLE_EN
        chk("auto_busy", 32'(bus1.o_busy), 1);
        chk("auto_left", 32'(bus1.o_cards_left), 0);
`else
        chk("drain_empty", 32'(bus1.o_empty), 1);
        chk("drain_ready", 32'(bus1.o_ready), 0);
        chk("drain_left",  32'(bus1.o_cards_left), 0);
        bus1.i_draw_req = 1'b1;
        @(negedge clk);
        bus1.i_draw_req = 1'b0;
        chk("draw53_valid", 32'(bus1.o_card_valid), 0);
        chk("draw53_left",  32'(bus1.o_cards_left), 0);
        chk("draw53_empty", 32'(bus1.o_empty), 1);
        bus1.i_shuffle_req = 1'b1;
        @(negedge clk);
        bus1.i_shuffle_req = 1'b0;
        chk("refill_busy", 32'(bus1.o_busy), 1);
        chk("refill_left", 32'(bus1.o_cards_left), 0);
`endif
        waitReady1(1000, 1'b1, "shuf2");

        // Draw and shuffle together at 40 left: shuffle wins.
        drawN1(12, D1, "pre40");
        chk("at40_left", 32'(bus1.o_cards_left), 40);
        bus1.i_draw_req    = 1'b1;
        bus1.i_shuffle_req = 1'b1;
        @(negedge clk);
        bus1.i_draw_req    = 1'b0;
        bus1.i_shuffle_req = 1'b0;
        chk("both_valid", 32'(bus1.o_card_valid), 0);
        chk("both_left",  32'(bus1.o_cards_left), 0);
        chk("both_busy",  32'(bus1.o_busy), 1);
        waitReady1(1000, 1'b1, "shuf3");

        // Reset in the middle of a shuffle, then replay.
        bus1.i_shuffle_req = 1'b1;
        @(negedge clk);
        bus1.i_shuffle_req = 1'b0;
        repeat (70) @(negedge clk);
        chk("mid_busy", 32'(bus1.o_busy), 1);
        #2;
        rst1 = 1'b0;
        #1;
        resetCheck1("midrst");
        @(negedge clk);
        rst1 = 1'b1;
        waitReady1(1000, 1'b0, "shuf4");
        drawN1(DRAIN1, D1, "drain2");
        mism = 0;
        foreach (run1[k]) begin
            if (k >= drawn.size() || drawn[k] !== run1[k]) mism++;
        end
        chk("replay_mism", mism, 0);

        // Two-deck shoe: back-to-back drain.
        n = 0;
        while (bus2.o_ready !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("d2_ready", 32'(bus2.o_ready), 1);
        chk("d2_left",  32'(bus2.o_cards_left), D2);
        q2.delete();
        for (int k = 0; k < DRAIN2; k++) begin
            bus2.i_draw_req = 1'b1;
            @(negedge clk);
            chk("d2_valid", 32'(bus2.o_card_valid), 1);
            q2.push_back(bus2.o_card);
        end
        bus2.i_draw_req = 1'b0;
        permCheck(q2, 2, FULL2, DRAIN2, "deck2");
`ifdef CARD_SHOE_AUTO_RESHUFFLE_EN
        chk("d2_auto_busy", 32'(bus2.o_busy), 1);
`else
        chk("d2_empty", 32'(bus2.o_empty), 1);
        chk("d2_end_left", 32'(bus2.o_cards_left), 0);
`endif
        @(negedge clk);
        chk("d2_idle_valid", 32'(bus2.o_card_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 asserts, fails);
        $finish;
    end

endmodule
